mem_ctrl: RTL and testbench

- Byte-serial memory controller sitting directly upstream of the IF stage.
- Shares one 8-bit synchronous RAM port between IF and MEM.
  - IF byte fetches pass straight through when MEM is idle.
  - MEM load/store requests of 1/2/4 bytes are serialized by an internal FSM and take priority over IF.
- Tags each returned byte with its owner so IF can tell its data from MEM's.
- Drives the MEM-busy stall that IF treats as an interruption.

---
 rtl/mem_ctrl_if.sv | 69 ++++++
 rtl/mem_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// mem_ctrl bus bundle: IF fetch, MEM load/store and RAM byte port.
// MEM_ALIGN_CHECK_EN adds the mem_misalign_o flag.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_request_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [1:0]        mem_request_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [1:0]        mem_width_i;
  logic              mem_signed_i;
  logic [31:0]       mem_wdata_i;
  logic [31:0]       mem_rdata_o;
  logic              mem_done_o;
  logic              mem_busy_o;
  logic [7:0]        data_o;
  logic [1:0]        if_or_mem_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic              ram_wr_o;
  logic [7:0]        ram_dout_o;
  logic [7:0]        ram_din_i;
`ifdef MEM_ALIGN_CHECK_EN
  logic              mem_misalign_o;
`endif

  modport slave (
    input  if_request_i,
    input  if_addr_i,
    input  mem_request_i,
    input  mem_addr_i,
    input  mem_width_i,
    input  mem_signed_i,
    input  mem_wdata_i,
    input  ram_din_i,
`ifdef MEM_ALIGN_CHECK_EN
    output mem_misalign_o,
`endif
    output mem_rdata_o,
    output mem_done_o,
    output mem_busy_o,
    output data_o,
    output if_or_mem_o,
    output ram_addr_o,
    output ram_wr_o,
    output ram_dout_o
  );

  modport master (
    output if_request_i,
    output if_addr_i,
    output mem_request_i,
    output mem_addr_i,
    output mem_width_i,
    output mem_signed_i,
    output mem_wdata_i,
    output ram_din_i,
`ifdef MEM_ALIGN_CHECK_EN
    input  mem_misalign_o,
`endif
    input  mem_rdata_o,
    input  mem_done_o,
    input  mem_busy_o,
    input  data_o,
    input  if_or_mem_o,
    input  ram_addr_o,
    input  ram_wr_o,
    input  ram_dout_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial RAM arbiter: IF fetch pass-through, MEM 1/2/4-byte FSM.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned MEM requests fault.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_STORE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [2:0]        r_cnt;
  logic [2:0]        r_n;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_signed;
  logic [23:0]       r_shift;
  logic [31:0]       r_rdata;
  logic              r_done;
  logic [1:0]        r_owner;

  logic [1:0]        w_state_nxt;
  logic [2:0]        w_cnt_nxt;
  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_ram_wr;
  logic [7:0]        w_ram_dout;
  logic [1:0]        w_owner_nxt;
  logic              w_accept;
  logic              w_ld_fin;
  logic              w_req_ld;
  logic              w_req_st;
  logic              w_req_any;
  logic [2:0]        w_n_in;
  logic              w_misalign;
  logic [31:0]       w_wsh;
  logic [7:0]        w_din;
  logic [31:0]       w_ld_res;

  assign w_req_ld  = (bus.mem_request_i == 2'b01);
  assign w_req_st  = (bus.mem_request_i == 2'b10);
  assign w_req_any = w_req_ld | w_req_st;
  assign w_din     = bus.ram_din_i;
  assign w_wsh     = r_wdata >> {r_cnt[1:0], 3'b000};

  // Byte count of the incoming request; width 11 behaves as word.
  always_comb begin
    w_n_in = 3'd4;
    unique case (1'b1)
      (bus.mem_width_i == 2'b00): w_n_in = 3'd1;
      (bus.mem_width_i == 2'b01): w_n_in = 3'd2;
      default:                    w_n_in = 3'd4;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign =
    ((w_n_in == 3'd2) & bus.mem_addr_i[0]) |
    ((w_n_in == 3'd4) & (bus.mem_addr_i[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Next state, RAM port mux and owner tag of this cycle's access.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ram_addr  = '0;
    w_ram_wr    = 1'b0;
    w_ram_dout  = 8'h00;
    w_owner_nxt = 2'b00;
    w_accept    = 1'b0;
    w_ld_fin    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req_any) begin
          w_accept = 1'b1;
          if (w_misalign) begin
            w_state_nxt = S_DONE;
          end else if (w_req_ld) begin
            w_ram_addr  = bus.mem_addr_i;
            w_owner_nxt = 2'b10;
            w_state_nxt = S_LOAD;
            w_cnt_nxt   = 3'd1;
          end else begin
            w_ram_addr  = bus.mem_addr_i;
            w_ram_wr    = 1'b1;
            w_ram_dout  = bus.mem_wdata_i[7:0];
            w_cnt_nxt   = 3'd1;
            if (w_n_in == 3'd1) w_state_nxt = S_DONE;
            else                w_state_nxt = S_STORE;
          end
        end else if (bus.if_request_i) begin
          w_ram_addr  = bus.if_addr_i;
          w_owner_nxt = 2'b01;
        end
      end
      S_LOAD: begin
        if (r_cnt < r_n) begin
          w_ram_addr  = r_addr + ADDR_W'(r_cnt);
          w_owner_nxt = 2'b10;
          w_cnt_nxt   = r_cnt + 3'd1;
        end else begin
          w_ld_fin    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_STORE: begin
        w_ram_addr = r_addr + ADDR_W'(r_cnt);
        w_ram_wr   = 1'b1;
        w_ram_dout = w_wsh[7:0];
        if (r_cnt == r_n - 3'd1) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Final load value: last byte comes straight from the RAM this cycle.
  always_comb begin
    w_ld_res = 32'h0;
    unique case (r_n)
      3'd1:    w_ld_res = {{24{r_signed & w_din[7]}}, w_din};
      3'd2:    w_ld_res = {{16{r_signed & w_din[7]}}, w_din, r_shift[7:0]};
      default: w_ld_res = {w_din, r_shift[23:0]};
    endcase
  end

  // FSM state, request latch and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 3'd0;
      r_n      <= 3'd1;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_signed <= 1'b0;
      r_rdata  <= 32'h0;
      r_done   <= 1'b0;
      r_owner  <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_owner <= w_owner_nxt;
      r_done  <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_addr   <= bus.mem_addr_i;
        r_n      <= w_n_in;
        r_wdata  <= bus.mem_wdata_i;
        r_signed <= bus.mem_signed_i;
      end
      if (w_ld_fin) r_rdata <= w_ld_res;
    end
  end

  // Collect load bytes 0..N-2 as they return from the RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= 24'h0;
    end else if (r_state == S_LOAD) begin
      case (r_cnt)
        3'd1:    r_shift[7:0]   <= w_din;
        3'd2:    r_shift[15:8]  <= w_din;
        3'd3:    r_shift[23:16] <= w_din;
        default: r_shift        <= r_shift;
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic r_misalign;

  // Fault flag pulses alongside done for a rejected request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= (r_state == S_IDLE) & w_req_any & w_misalign;
    end
  end

  assign bus.mem_misalign_o = r_misalign;
`endif

  assign bus.ram_addr_o  = rst ? w_ram_addr : '0;
  assign bus.ram_wr_o    = rst & w_ram_wr;
  assign bus.ram_dout_o  = w_ram_dout;
  assign bus.data_o      = w_din;
  assign bus.if_or_mem_o = r_owner;
  assign bus.mem_rdata_o = r_rdata;
  assign bus.mem_done_o  = r_done;
  assign bus.mem_busy_o  = (r_state == S_LOAD) | (r_state == S_STORE) |
                           ((r_state == S_IDLE) & w_req_any);

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl with a byte RAM and a reference model.
// Build with MEM_ALIGN_CHECK_EN to exercise the misalignment fault path.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ram_clr = 1'b1;

  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(32)) bus();

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0]    ram [4096];
  logic [4095:0] wflag;
  logic [7:0]    rd_q;
  logic [7:0]    ref_mem [4096];
  logic [31:0]   last_rd;
  int            n_checks = 0;
  int            n_fail = 0;

  function automatic logic [7:0] init_byte(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[3:0]} ^ 8'hA5;
  endfunction

  always @(posedge clk) begin
    if (ram_clr) begin
      wflag <= '0;
    end else if (bus.ram_wr_o) begin
      ram[bus.ram_addr_o[11:0]]   <= bus.ram_dout_o;
      wflag[bus.ram_addr_o[11:0]] <= 1'b1;
    end
    rd_q <= wflag[bus.ram_addr_o[11:0]] ? ram[bus.ram_addr_o[11:0]]
                                        : init_byte(bus.ram_addr_o[11:0]);
  end

  assign bus.ram_din_i = rd_q;

  task automatic do_mem(input bit is_st, input logic [31:0] a,
                        input logic [1:0] w, input bit sg,
                        input logic [31:0] wd, input bit if_also,
                        output logic [31:0] got);
    int n, last, busy_cnt, own_cnt, own_exp;
    bit mis;
    logic [63:0] v;
    logic [31:0] exp_rd, ak, sh;
    n = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`endif
    exp_rd = last_rd;
    if (!is_st && !mis) begin
      v = 64'h0;
      for (int k = 0; k < n; k++) begin
        ak = a + 32'(k);
        v = v | (64'(ref_mem[ak[11:0]]) << (8 * k));
      end
      if (sg && v[8*n-1]) v = v - (64'd1 << (8 * n));
      exp_rd = v[31:0];
    end
    last = mis ? 1 : (is_st ? n : n + 1);
    own_exp = (!is_st && !mis) ? n : 0;
    busy_cnt = 0;
    own_cnt = 0;
    got = 32'h0;
    @(negedge clk);
    bus.mem_request_i = is_st ? 2'b10 : 2'b01;
    bus.mem_addr_i = a;
    bus.mem_width_i = w;
    bus.mem_signed_i = sg;
    bus.mem_wdata_i = wd;
    bus.if_request_i = if_also;
    bus.if_addr_i = 32'($urandom_range(0, 4095));
    for (int t = 0; t <= last; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      if (bus.mem_busy_o) busy_cnt++;
      if (t > 0 && bus.if_or_mem_o == 2'b10) own_cnt++;
      n_checks++;
      if (bus.mem_done_o !== 1'(t == last)) begin
        $display("FAIL done t=%0d a=%h got %b want %b",
                 t, a, bus.mem_done_o, t == last);
        n_fail++;
      end
      ak = a + 32'(t);
      sh = wd >> (8 * t);
      if (!mis && is_st && t < n) begin
        n_checks++;
        if ({bus.ram_wr_o, bus.ram_addr_o, bus.ram_dout_o} !==
            {1'b1, ak, sh[7:0]}) begin
          $display("FAIL store_port t=%0d got wr=%b a=%h d=%h want a=%h d=%h",
                   t, bus.ram_wr_o, bus.ram_addr_o, bus.ram_dout_o,
                   ak, sh[7:0]);
          n_fail++;
        end
      end else if (!mis && !is_st && t < n) begin
        n_checks++;
        if ({bus.ram_wr_o, bus.ram_addr_o} !== {1'b0, ak}) begin
          $display("FAIL load_port t=%0d got wr=%b a=%h want a=%h",
                   t, bus.ram_wr_o, bus.ram_addr_o, ak);
          n_fail++;
        end
      end else begin
        n_checks++;
        if (bus.ram_wr_o !== 1'b0) begin
          $display("FAIL no_write t=%0d got %b want 0", t, bus.ram_wr_o);
          n_fail++;
        end
      end
      if (!is_st && !mis && t >= 1 && t <= n) begin
        ak = a + 32'(t - 1);
        n_checks++;
        if (bus.data_o !== ref_mem[ak[11:0]]) begin
          $display("FAIL load_byte t=%0d got %h want %h",
                   t, bus.data_o, ref_mem[ak[11:0]]);
          n_fail++;
        end
      end
      if (t == last) begin
        got = bus.mem_rdata_o;
        n_checks++;
        if (bus.mem_rdata_o !== exp_rd) begin
          $display("FAIL rdata a=%h w=%0d s=%b st=%b got %h want %h",
                   a, w, sg, is_st, bus.mem_rdata_o, exp_rd);
          n_fail++;
        end
`ifdef MEM_ALIGN_CHECK_EN
        n_checks++;
        if (bus.mem_misalign_o !== mis) begin
          $display("FAIL misalign a=%h got %b want %b",
                   a, bus.mem_misalign_o, mis);
          n_fail++;
        end
`endif
      end
    end
    n_checks++;
    if (busy_cnt != last) begin
      $display("FAIL busy_cycles a=%h got %0d want %0d", a, busy_cnt, last);
      n_fail++;
    end
    n_checks++;
    if (own_cnt != own_exp) begin
      $display("FAIL owner_mem_cycles a=%h got %0d want %0d",
               a, own_cnt, own_exp);
      n_fail++;
    end
    if (is_st && !mis) begin
      for (int k = 0; k < n; k++) begin
        ak = a + 32'(k);
        sh = wd >> (8 * k);
        ref_mem[ak[11:0]] = sh[7:0];
      end
    end
    if (!is_st && !mis) last_rd = exp_rd;
  endtask

  task automatic test_reset();
    bus.if_request_i = 1'b1;
    bus.if_addr_i = 32'h123;
    bus.mem_request_i = 2'b01;
    bus.mem_addr_i = 32'h456;
    bus.mem_width_i = 2'b10;
    bus.mem_signed_i = 1'b0;
    bus.mem_wdata_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ram_clr = 1'b0;
      #1;
      n_checks++;
      if ({bus.ram_wr_o, bus.ram_addr_o} !== 33'h0) begin
        $display("FAIL reset_port got wr=%b a=%h want 0",
                 bus.ram_wr_o, bus.ram_addr_o);
        n_fail++;
      end
      n_checks++;
      if ({bus.mem_done_o, bus.if_or_mem_o, bus.mem_rdata_o} !== 35'h0) begin
        $display("FAIL reset_regs got done=%b own=%b rd=%h want 0",
                 bus.mem_done_o, bus.if_or_mem_o, bus.mem_rdata_o);
        n_fail++;
      end
    end
    @(negedge clk);
    bus.mem_request_i = 2'b00;
    bus.if_request_i = 1'b0;
    rst = 1'b1;
    last_rd = 32'h0;
  endtask

  task automatic test_if_fetch();
    logic [31:0] got, prev;
    do_mem(1'b1, 32'h100, 2'b00, 1'b0, 32'h13, 1'b0, got);
    prev = 32'h0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.mem_request_i = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
      bus.if_request_i = 1'b1;
      bus.if_addr_i = (i == 0) ? 32'h100 : 32'($urandom_range(0, 4095));
      #1;
      n_checks++;
      if ({bus.ram_wr_o, bus.ram_addr_o, bus.mem_busy_o} !==
          {1'b0, bus.if_addr_i, 1'b0}) begin
        $display("FAIL if_port got wr=%b a=%h busy=%b want a=%h",
                 bus.ram_wr_o, bus.ram_addr_o, bus.mem_busy_o, bus.if_addr_i);
        n_fail++;
      end
      if (i > 0) begin
        n_checks++;
        if ({bus.if_or_mem_o, bus.data_o} !== {2'b01, ref_mem[prev[11:0]]}) begin
          $display("FAIL if_data got own=%b d=%h want own=01 d=%h",
                   bus.if_or_mem_o, bus.data_o, ref_mem[prev[11:0]]);
          n_fail++;
        end
      end
      if (i == 1) begin
        n_checks++;
        if (bus.data_o !== 8'h13) begin
          $display("FAIL if_0x100 got %h want 13", bus.data_o);
          n_fail++;
        end
      end
      prev = bus.if_addr_i;
    end
    @(negedge clk);
    bus.if_request_i = 1'b0;
    bus.mem_request_i = 2'b00;
    #1;
    n_checks++;
    if ({bus.if_or_mem_o, bus.ram_addr_o} !== {2'b01, 32'h0}) begin
      $display("FAIL if_last got own=%b a=%h want own=01 a=0",
               bus.if_or_mem_o, bus.ram_addr_o);
      n_fail++;
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.if_or_mem_o !== 2'b00) begin
      $display("FAIL idle_owner got %b want 00", bus.if_or_mem_o);
      n_fail++;
    end
  endtask

  task automatic test_word_load();
    logic [31:0] got;
    do_mem(1'b1, 32'h200, 2'b10, 1'b0, 32'h12345678, 1'b0, got);
    do_mem(1'b0, 32'h200, 2'b10, 1'b0, 32'h0, 1'b0, got);
    n_checks++;
    if (got !== 32'h12345678) begin
      $display("FAIL word_load got %h want 12345678", got);
      n_fail++;
    end
  endtask

  task automatic test_sign();
    logic [31:0] got;
    logic [31:0] want [4];
    want[0] = 32'hFFFFFF80;
    want[1] = 32'h00000080;
    want[2] = 32'hFFFF8001;
    want[3] = 32'h00008001;
    do_mem(1'b1, 32'h400, 2'b00, 1'b0, 32'h80, 1'b0, got);
    do_mem(1'b1, 32'h402, 2'b01, 1'b0, 32'h8001, 1'b0, got);
    for (int i = 0; i < 4; i++) begin
      do_mem(1'b0, (i < 2) ? 32'h400 : 32'h402, (i < 2) ? 2'b00 : 2'b01,
             (i % 2) == 0, 32'h0, 1'b0, got);
      n_checks++;
      if (got !== want[i]) begin
        $display("FAIL sign_ext case=%0d got %h want %h", i, got, want[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_half_store_if();
    logic [31:0] got;
    do_mem(1'b1, 32'h300, 2'b01, 1'b0, 32'hBEEF, 1'b1, got);
    do_mem(1'b0, 32'h300, 2'b01, 1'b0, 32'h0, 1'b0, got);
    n_checks++;
    if (got !== 32'h0000BEEF) begin
      $display("FAIL half_store got %h want 0000beef", got);
      n_fail++;
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] got, ia;
    do_mem(1'b0, 32'h200, 2'b10, 1'b1, 32'h0, 1'b1, got);
    @(negedge clk);
    bus.mem_request_i = 2'b00;
    ia = bus.if_addr_i;
    #1;
    n_checks++;
    if ({bus.ram_addr_o, bus.mem_busy_o} !== {ia, 1'b0}) begin
      $display("FAIL if_after_done got a=%h busy=%b want a=%h",
               bus.ram_addr_o, bus.mem_busy_o, ia);
      n_fail++;
    end
    @(negedge clk);
    bus.if_request_i = 1'b0;
    #1;
    n_checks++;
    if ({bus.if_or_mem_o, bus.data_o} !== {2'b01, ref_mem[ia[11:0]]}) begin
      $display("FAIL if_served got own=%b d=%h want own=01 d=%h",
               bus.if_or_mem_o, bus.data_o, ref_mem[ia[11:0]]);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    @(negedge clk);
    bus.mem_request_i = 2'b10;
    bus.mem_addr_i = 32'h700;
    bus.mem_width_i = 2'b10;
    bus.mem_wdata_i = 32'hAABBCCDD;
    bus.if_request_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.ram_wr_o, bus.ram_addr_o, bus.mem_done_o,
         bus.if_or_mem_o, bus.mem_rdata_o} !== 68'h0) begin
      $display("FAIL reset_mid got wr=%b a=%h done=%b own=%b rd=%h want 0",
               bus.ram_wr_o, bus.ram_addr_o, bus.mem_done_o,
               bus.if_or_mem_o, bus.mem_rdata_o);
      n_fail++;
    end
    ref_mem[12'h700] = 8'hDD;
    ref_mem[12'h701] = 8'hCC;
    last_rd = 32'h0;
    @(negedge clk);
    bus.mem_request_i = 2'b00;
    bus.if_request_i = 1'b0;
    rst = 1'b1;
    do_mem(1'b0, 32'h700, 2'b10, 1'b0, 32'h0, 1'b0, got);
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_misalign();
    logic [31:0] got;
    do_mem(1'b0, 32'h201, 2'b10, 1'b0, 32'h0, 1'b0, got);
    do_mem(1'b1, 32'h303, 2'b01, 1'b0, 32'h1234, 1'b0, got);
    do_mem(1'b0, 32'h300, 2'b01, 1'b0, 32'h0, 1'b0, got);
  endtask
`endif

  task automatic test_random();
    logic [31:0] got, a;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0)
        a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      else
        a = 32'h600 + 32'($urandom_range(0, 63));
      do_mem($urandom_range(0, 1) == 1, a, 2'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
             got);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bus.mem_request_i = 2'b00;
        bus.if_request_i = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(12'(i));
    last_rd = 32'h0;
    test_reset();
    test_if_fetch();
    test_word_load();
    test_sign();
    test_half_store_if();
    test_simultaneous();
    test_reset_mid();
`ifdef MEM_ALIGN_CHECK_EN
    test_misalign();
`endif
    test_random();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
